// File: rtl/cmp_pipe.sv
// Two-stage pipelined comparator: unsigned, signed and FP32 modes.
// Stage 1 registers slice G/E/L plus class bits, stage 2 the final result.
module cmp_pipe #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 2,
  parameter int FP_EN = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [1:0]       mode_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic             lt_o,
  output logic             eq_o,
  output logic             gt_o,
  output logic             unord_o,
  output logic             snan_o
);

  localparam int N  = WIDTH / CHUNK;
  localparam bit FP = (FP_EN != 0) && (WIDTH == 32);

  logic adv1;
  logic adv2;
  logic s1_valid;

  assign adv2       = ~out_valid_o | out_ready_i;
  assign adv1       = ~s1_valid | adv2;
  assign in_ready_o = adv1;

  logic [N-1:0] g_d;
  logic [N-1:0] e_d;
  logic [N-1:0] l_d;

  for (genvar i = 0; i < N; i++) begin : g_slice
    logic [CHUNK-1:0] sa;
    logic [CHUNK-1:0] sb;
    assign sa     = a_i[i*CHUNK +: CHUNK];
    assign sb     = b_i[i*CHUNK +: CHUNK];
    assign g_d[i] = sa > sb;
    assign e_d[i] = sa == sb;
    assign l_d[i] = sa < sb;
  end

  // FP class decode on a fixed 31-bit view so any WIDTH elaborates
  logic [30:0] a31;
  logic [30:0] b31;
  logic        fp_sel;
  logic        sg_sel;
  logic        nan_a;
  logic        nan_b;
  logic        snan_d;
  logic        zero_d;

  assign a31    = 31'(a_i);
  assign b31    = 31'(b_i);
  assign fp_sel = FP && (mode_i == 2'b10);
  assign sg_sel = (mode_i == 2'b01);
  assign nan_a  = (&a31[30:23]) & (|a31[22:0]);
  assign nan_b  = (&b31[30:23]) & (|b31[22:0]);
  assign snan_d = (nan_a & ~a31[22]) | (nan_b & ~b31[22]);
  assign zero_d = ~(|a31) & ~(|b31);

  logic [N-1:0] s1_g;
  logic [N-1:0] s1_e;
  logic [N-1:0] s1_l;
  logic [1:0]   s1_mode;
  logic         s1_sa;
  logic         s1_sb;
  logic         s1_nan;
  logic         s1_snan;
  logic         s1_zero;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_valid <= 1'b0;
      s1_g     <= '0;
      s1_e     <= '0;
      s1_l     <= '0;
      s1_mode  <= '0;
      s1_sa    <= 1'b0;
      s1_sb    <= 1'b0;
      s1_nan   <= 1'b0;
      s1_snan  <= 1'b0;
      s1_zero  <= 1'b0;
    end else if (flush_i) begin
      s1_valid <= 1'b0;
    end else if (adv1) begin
      s1_valid <= in_valid_i;
      if (in_valid_i) begin
        s1_g    <= g_d;
        s1_e    <= e_d;
        s1_l    <= l_d;
        s1_mode <= {fp_sel, sg_sel};
        s1_sa   <= a_i[WIDTH-1];
        s1_sb   <= b_i[WIDTH-1];
        s1_nan  <= fp_sel & (nan_a | nan_b);
        s1_snan <= fp_sel & snan_d;
        s1_zero <= fp_sel & zero_d;
      end
    end
  end

  // Most-significant unequal slice decides the magnitude result
  logic mg;
  logic ml;
  logic meq;

  always_comb begin
    mg = 1'b0;
    ml = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!s1_e[i]) begin
        mg = s1_g[i];
        ml = s1_l[i];
      end
    end
  end

  assign meq = &s1_e;

  logic fp_k;
  logic sg_k;
  logic r_lt;
  logic r_eq;
  logic r_gt;
  logic r_un;

  assign fp_k = s1_mode[1];
  assign sg_k = s1_mode[0];

  always_comb begin
    r_lt = ml;
    r_eq = meq;
    r_gt = mg;
    r_un = 1'b0;
    if (fp_k && s1_nan) begin
      r_lt = 1'b0;
      r_eq = 1'b0;
      r_gt = 1'b0;
      r_un = 1'b1;
    end else if (fp_k && s1_zero) begin
      r_lt = 1'b0;
      r_eq = 1'b1;
      r_gt = 1'b0;
    end else if ((fp_k || sg_k) && (s1_sa != s1_sb)) begin
      r_lt = s1_sa;
      r_eq = 1'b0;
      r_gt = s1_sb;
    end else if (fp_k && s1_sa) begin
      r_lt = mg;
      r_gt = ml;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_valid_o <= 1'b0;
      lt_o        <= 1'b0;
      eq_o        <= 1'b0;
      gt_o        <= 1'b0;
      unord_o     <= 1'b0;
      snan_o      <= 1'b0;
    end else if (flush_i) begin
      out_valid_o <= 1'b0;
    end else if (adv2) begin
      out_valid_o <= s1_valid;
      if (s1_valid) begin
        lt_o    <= r_lt;
        eq_o    <= r_eq;
        gt_o    <= r_gt;
        unord_o <= r_un;
        snan_o  <= s1_snan;
      end
    end
  end

endmodule

// File: tb/tb_cmp_pipe.sv
// Self-checking bench for cmp_pipe: directed cases plus a
// scoreboard fed at accept time and drained at output time.
module tb_cmp_pipe;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  mode;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic        out_ready;
  logic        lt, eq, gt, unord, snan;

  int checks = 0;
  int errors = 0;

  logic [4:0] sb_q[$];

  cmp_pipe #(.WIDTH(32), .CHUNK(2), .FP_EN(1)) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .flush_i    (flush),
    .in_valid_i (in_valid),
    .in_ready_o (in_ready),
    .mode_i     (mode),
    .a_i        (a),
    .b_i        (b),
    .out_valid_o(out_valid),
    .out_ready_i(out_ready),
    .lt_o       (lt),
    .eq_o       (eq),
    .gt_o       (gt),
    .unord_o    (unord),
    .snan_o     (snan)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: {lt, eq, gt, unord, snan}
  function automatic logic [4:0] model(input logic [1:0] m,
                                       input logic [31:0] x,
                                       input logic [31:0] y);
    logic   nx, ny, sx, sy;
    longint kx, ky;
    if (m == 2'b01) begin
      return {$signed(x) < $signed(y), x == y,
              $signed(x) > $signed(y), 2'b00};
    end
    if (m == 2'b10) begin
      nx = (x[30:23] == 8'hff) && (x[22:0] != 0);
      ny = (y[30:23] == 8'hff) && (y[22:0] != 0);
      sx = nx && !x[22];
      sy = ny && !y[22];
      if (nx || ny) return {3'b000, 1'b1, sx || sy};
      kx = x[31] ? -longint'(x[30:0]) : longint'(x[30:0]);
      ky = y[31] ? -longint'(y[30:0]) : longint'(y[30:0]);
      return {kx < ky, kx == ky, kx > ky, 2'b00};
    end
    return {x < y, x == y, x > y, 2'b00};
  endfunction

  always @(negedge clk) begin
    logic [4:0] exp_v;
    logic [4:0] got_v;
    if (!rst_n) begin
      sb_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        got_v = {lt, eq, gt, unord, snan};
        checks++;
        if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected got=%b required=none", got_v);
        end else begin
          exp_v = sb_q.pop_front();
          if (got_v !== exp_v) begin
            errors++;
            $display("FAIL sb_result got=%b required=%b", got_v, exp_v);
          end
        end
        checks++;
        if (3'(lt) + 3'(eq) + 3'(gt) + 3'(unord) !== 3'd1) begin
          errors++;
          $display("FAIL onehot got=%b required one bit", got_v[4:1]);
        end
      end
      if (flush) sb_q.delete();
      else if (in_valid && in_ready) sb_q.push_back(model(mode, a, b));
    end
  end

  task automatic send(input logic [1:0] m, input logic [31:0] x,
                      input logic [31:0] y);
    bit ok = 0;
    mode = m; a = x; b = y; in_valid = 1'b1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1; break; end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL send_timeout got=in_ready=0 required=1");
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    bit ok = 0;
    out_ready = 1'b1;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (sb_q.size() == 0 && !out_valid) begin ok = 1; break; end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL drain got=%0d pending required=0", sb_q.size());
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 0; in_valid = 0; out_ready = 1;
    mode = 0; a = 0; b = 0;
    repeat (3) @(negedge clk);
    checks++;
    if ({out_valid, lt, eq, gt, unord, snan} !== 6'b0) begin
      errors++;
      $display("FAIL reset_outs got=%b required=000000",
               {out_valid, lt, eq, gt, unord, snan});
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready got=%b required=1", in_ready);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_latency();
    out_ready = 1'b1;
    mode = 2'b00; a = 32'h8000_0000; b = 32'h7FFF_FFFF; in_valid = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL first_accept got=%b required=1", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL lat_cycle1 got=%b required=0", out_valid);
    end
    @(negedge clk);
    checks++;
    if ({out_valid, gt} !== 2'b11) begin
      errors++;
      $display("FAIL lat_cycle2 got=%b required=11", {out_valid, gt});
    end
    wait_drain();
  endtask

  task automatic test_directed();
    logic [1:0]  tm[11];
    logic [31:0] ta[11];
    logic [31:0] tb[11];
    logic [4:0]  te[11];
    bit          ok;
    tm = '{2'b00, 2'b01, 2'b10, 2'b10, 2'b10, 2'b10,
           2'b11, 2'b10, 2'b01, 2'b00, 2'b10};
    ta = '{32'h80000000, 32'h80000000, 32'h80000000, 32'hBF800000,
           32'h7FA00000, 32'h7FC00000, 32'h80000000, 32'h3F800000,
           32'hFFFFFFFF, 32'h12345678, 32'h3F800000};
    tb = '{32'h7FFFFFFF, 32'h7FFFFFFF, 32'h00000000, 32'hC0000000,
           32'h3F800000, 32'h3F800000, 32'h7FFFFFFF, 32'hBF800000,
           32'hFFFFFFFE, 32'h12345678, 32'h7FA00000};
    te = '{5'b00100, 5'b10000, 5'b01000, 5'b00100, 5'b00011,
           5'b00010, 5'b00100, 5'b00100, 5'b00100, 5'b01000, 5'b00011};
    out_ready = 1'b1;
    for (int i = 0; i < 11; i++) begin
      send(tm[i], ta[i], tb[i]);
      ok = 0;
      for (int k = 0; k < 10; k++) begin
        @(negedge clk);
        if (out_valid) begin ok = 1; break; end
      end
      checks++;
      if (!ok || {lt, eq, gt, unord, snan} !== te[i]) begin
        errors++;
        $display("FAIL directed_%0d got=%b required=%b", i,
                 {lt, eq, gt, unord, snan}, te[i]);
      end
      @(posedge clk); #1;
    end
    wait_drain();
  endtask

  task automatic test_backpressure();
    int         idx = 0;
    bit         acc;
    logic [4:0] held;
    out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      mode = 2'(idx); a = 32'h1000 * idx; b = 32'h2000; in_valid = 1'b1;
      @(negedge clk);
      acc = in_ready;
      @(posedge clk); #1;
      if (acc) idx++;
    end
    @(negedge clk);
    checks++;
    if (idx !== 2 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL bp_full got=%0d/%b required=2/0", idx, in_ready);
    end
    held = {lt, eq, gt, unord, snan};
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if ({out_valid, lt, eq, gt, unord, snan} !== {1'b1, held}) begin
      errors++;
      $display("FAIL bp_hold got=%b required=%b",
               {out_valid, lt, eq, gt, unord, snan}, {1'b1, held});
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    for (int c = 0; c < 20 && idx < 4; c++) begin
      mode = 2'(idx); a = 32'h1000 * idx; b = 32'h2000; in_valid = 1'b1;
      @(negedge clk);
      acc = in_ready;
      @(posedge clk); #1;
      if (acc) idx++;
    end
    in_valid = 1'b0;
    checks++;
    if (idx !== 4) begin
      errors++;
      $display("FAIL bp_release got=%0d required=4", idx);
    end
    wait_drain();
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      mode = 2'(c); a = $urandom; b = $urandom; in_valid = 1'b1;
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b1 || (c >= 2 && out_valid !== 1'b1)) begin
        errors++;
        $display("FAIL b2b_%0d got=%b%b required=11", c, in_ready,
                 out_valid);
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    wait_drain();
  endtask

  task automatic test_flush();
    out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      mode = 2'b00; a = 32'd5 + c; b = 32'd6; in_valid = 1'b1;
      flush = (c == 2);
      @(posedge clk); #1;
    end
    flush = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_clear got=%b required=0", out_valid);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_s1 got=%b required=0", out_valid);
    end
    @(posedge clk); #1;
    send(2'b01, 32'hFFFF_FFF0, 32'd3);
    wait_drain();
  endtask

  task automatic test_reset_midop();
    int seen = 0;
    out_ready = 1'b0;
    send(2'b00, 32'd1, 32'd2);
    send(2'b00, 32'd3, 32'd2);
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_async got=%b%b required=01", out_valid, in_ready);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL rst_discard got=%0d required=0", seen);
    end
    @(posedge clk); #1;
    send(2'b10, 32'hBF80_0000, 32'h3F80_0000);
    wait_drain();
  endtask

  task automatic test_random();
    bit          acc;
    logic [31:0] pool[6];
    pool = '{32'h0, 32'h8000_0000, 32'h7FC0_0000, 32'h7F80_0001,
             32'hFF80_0000, 32'h7FFF_FFFF};
    in_valid = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      if (!in_valid || acc) begin
        mode = 2'($urandom_range(0, 3));
        a = ($urandom_range(0, 3) == 0) ? pool[$urandom_range(0, 5)]
                                        : $urandom;
        b = ($urandom_range(0, 3) == 0) ? pool[$urandom_range(0, 5)]
                                        : $urandom;
        if ($urandom_range(0, 7) == 0) b = a;
        if ($urandom_range(0, 7) == 0) b = a ^ 32'h8000_0000;
        in_valid = ($urandom_range(0, 3) != 0);
      end
      out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      acc = in_valid && in_ready;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    wait_drain();
  endtask

  initial begin
    test_reset();
    test_latency();
    test_directed();
    test_backpressure();
    test_back_to_back();
    test_flush();
    test_reset_midop();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cmp_pipe.md
CMP_PIPE -- requirements
Module: cmp_pipe

Interface
REQ-001 Parameter WIDTH, default 32, operand width in bits; legal values 8..64 and a multiple of CHUNK.
REQ-002 Parameter CHUNK, default 2, bits per stage-1 slice comparator; legal values 1, 2, 4 or 8.
REQ-003 Parameter FP_EN, default 1, enables FP32 compare mode; legal only when WIDTH==32, otherwise tied 0.
REQ-004 clk_i  in  1  single clock; all state updates on the rising edge.
REQ-005 rst_ni  in  1  reset, asynchronous assert and active-low.
REQ-006 flush_i  in  1  synchronous clear of all in-flight operations.
REQ-007 in_valid_i  in  1  operand pair valid.
REQ-008 in_ready_o  out  1  block accepts the operand pair this cycle.
REQ-009 mode_i  in  2  compare mode: 00 unsigned, 01 signed two's-complement, 10 FP32, 11 reserved (treated as unsigned).
REQ-010 a_i, b_i  in  WIDTH  operands A and B.
REQ-011 out_valid_o  out  1  result valid.
REQ-012 out_ready_i  in  1  consumer accepts the result.
REQ-013 lt_o, eq_o, gt_o  out  1 each  A<B, A==B, A>B.
REQ-014 unord_o  out  1  FP unordered result: either operand is NaN.
REQ-015 snan_o  out  1  either operand is a signalling NaN.

Function
REQ-016 Stage 1 (S1) registers, per CHUNK slice, the slice G/E/L, the mode, the operand sign bits and the FP class bits (NaN, sNaN, both-zero).
REQ-017 Stage 2 (S2) registers the final result; the result is the most-significant slice whose E is 0, else E.
REQ-018 Latency is exactly 2 cycles from an accept (in_valid_i&in_ready_o) to out_valid_o, absent stalls.
REQ-019 Throughput is 1 result per cycle while out_ready_i=1.
REQ-020 The stage 2 advance condition is adv2 = ~out_valid_o | out_ready_i.
REQ-021 The stage 1 advance condition is adv1 = ~s1_valid | adv2.
REQ-022 in_ready_o = adv1, combinationally; no input-to-output combinational path other than out_ready_i to in_ready_o.
REQ-023 When a stage does not advance, that stage holds its data and output fields stable while out_valid_o=1 and out_ready_i=0.
REQ-024 Exactly one of lt_o/eq_o/gt_o is 1 whenever out_valid_o=1 and unord_o=0.
REQ-025 Unsigned mode: plain magnitude compare; unord_o=snan_o=0.
REQ-026 Signed mode: when signs differ, the negative operand is less; when signs match, the magnitude compare of the remaining bits is used.
REQ-027 FP32 mode, any NaN operand: lt=eq=gt=0 and unord=1.
REQ-028 FP32 mode, sNaN detection: snan_o=1 when an operand has exponent 0xFF, mantissa nonzero and mantissa bit 22 equal to 0.
REQ-029 FP32 mode: +0 and -0 compare equal.
REQ-030 FP32 mode, both operands negative: the magnitude result is inverted (lt and gt swapped).
REQ-031 FP32 mode, signs differ and not both zero: the negative operand is less.
REQ-032 Reserved mode 11 produces results identical to mode 00.
REQ-033 flush_i=1 clears s1_valid and out_valid_o on the next edge and takes priority over a same-cycle accept.
REQ-034 in_ready_o remains functionally driven (adv1) during flush_i=1.
REQ-035 A transfer with in_valid_i=1, out_valid_o=1 and out_ready_i=1 in the same cycle is a simultaneous accept and drain; the pipeline shifts and no bubble is inserted.

Reset
REQ-036 While rst_ni=0: s1_valid=0, out_valid_o=0, and lt_o, eq_o, gt_o, unord_o, snan_o are all 0.
REQ-037 While rst_ni=0, in_ready_o=1.
REQ-038 Reset asserted mid-operation discards all in-flight results; none appear after deassertion.
REQ-039 The first accept is allowed in the first cycle after rst_ni deasserts.

Verification
REQ-040 Unsigned: A=0x80000000, B=0x7FFFFFFF -> gt=1; same operands in signed mode -> lt=1; result appears on cycle 2 after accept.
REQ-041 FP32: A=0x80000000, B=0x00000000 -> eq=1; A=0xBF800000 (-1.0), B=0xC0000000 (-2.0) -> gt=1.
REQ-042 FP32: A=0x7FA00000 (sNaN), B=0x3F800000 -> unord=1, snan=1, lt=eq=gt=0; A=0x7FC00000 (qNaN) -> unord=1, snan=0.
REQ-043 Back-pressure: stream 4 pairs with out_ready_i=0 for 3 cycles -> at most 2 held in the pipeline, in_ready_o=0 when full, no loss or reordering after release.
REQ-044 flush_i asserted with 2 in flight plus a same-cycle accept -> out_valid_o=0 next cycle; the next accepted pair completes normally.
REQ-045 Randomised: 10^5 pairs per mode for WIDTH=8/32/64, CHUNK=1/2/4/8, random valid/ready -> every result matches a scoreboard model, and lt+eq+gt+unord==1 on every output.
